// File: rtl/uart_packet_parser.sv
module uart_packet_parser #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 12000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_available,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       rx_drop,
  output logic       busy
);

  localparam int unsigned   TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned   IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic          prev_avail_q;
  logic [7:0]    len_q, len_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    wr_idx_q, wr_idx_d;
  logic [7:0]    rd_idx_q, rd_idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_drop_q, rx_drop_d;
  logic [7:0]    mem_q [MAX_LEN];
  logic          strobe;
  logic          mem_we;
  logic          drain_last;

  always_comb begin
    strobe     = rx_byte_available & ~prev_avail_q;
    out_valid  = (state_q == S_DRAIN);
    drain_last = (rd_idx_q == len_q - 8'd1);
    out_last   = out_valid & drain_last;
    // Buffer is never reset, so data is masked outside DRAIN to keep outputs 0 after reset.
    out_data   = out_valid ? mem_q[rd_idx_q[IW-1:0]] : '0;
    busy       = (state_q != S_HUNT);
    frame_ok   = frame_ok_q;
    frame_err  = frame_err_q;
    rx_drop    = rx_drop_q;
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    chk_d       = chk_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    tmo_d       = '0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_drop_d   = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_HUNT: begin
        if (strobe && (rx_byte == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end

      S_LEN, S_PAYLOAD, S_CHK: begin
        // A strobe always takes priority over a coincident timeout expiry.
        if (strobe) begin
          tmo_d = '0;
          case (state_q)
            S_LEN: begin
              if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
                frame_err_d = 1'b1;
                state_d     = S_HUNT;
              end else begin
                len_d    = rx_byte;
                chk_d    = rx_byte;
                wr_idx_d = '0;
                state_d  = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              mem_we   = 1'b1;
              chk_d    = chk_q ^ rx_byte;
              wr_idx_d = wr_idx_q + 8'd1;
              if ((wr_idx_q + 8'd1) == len_q) begin
                state_d = S_CHK;
              end
            end
            default: begin
              if (rx_byte == chk_q) begin
                frame_ok_d = 1'b1;
                rd_idx_d   = '0;
                state_d    = S_DRAIN;
              end else begin
                frame_err_d = 1'b1;
                state_d     = S_HUNT;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          state_d     = S_HUNT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_DRAIN: begin
        rx_drop_d = strobe;
        if (out_ready) begin
          rd_idx_d = rd_idx_q + 8'd1;
          if (drain_last) begin
            state_d = S_HUNT;
          end
        end
      end

      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HUNT;
      prev_avail_q <= 1'b1;
      len_q        <= '0;
      chk_q        <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      tmo_q        <= '0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_avail_q <= rx_byte_available;
      len_q        <= len_d;
      chk_q        <= chk_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      tmo_q        <= tmo_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      rx_drop_q    <= rx_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx_q[IW-1:0]] <= rx_byte;
    end
  end

endmodule
